// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: load/store control encodings,
// arbiter FSM states and grant identifiers.
package mem_port_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;

  // Encoding shared with the control unit's LdStCtrl field.
  typedef enum logic [2:0] {
    LDST_LB  = 3'b000,
    LDST_LH  = 3'b001,
    LDST_LW  = 3'b010,
    LDST_LBU = 3'b011,
    LDST_LHU = 3'b100,
    LDST_SB  = 3'b101,
    LDST_SH  = 3'b110,
    LDST_SW  = 3'b111
  } ldst_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_IF_BUSY = 2'b01,
    ST_DM_BUSY = 2'b10,
    ST_DONE    = 2'b11
  } state_e;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_DM = 1'b1
  } grant_e;

  function automatic logic is_store(input ldst_e op);
    return (op == LDST_SB) || (op == LDST_SH) || (op == LDST_SW);
  endfunction

  // Widen a selected byte or halfword lane to a full word.
  function automatic logic [DATA_W-1:0] extend_lane(input logic [15:0] lane,
                                                    input logic        half,
                                                    input logic        sgn);
    logic fill;
    fill = sgn & (half ? lane[15] : lane[7]);
    return half ? {{16{fill}}, lane} : {{24{fill}}, lane[7:0]};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational big-endian lane logic: store byte mask and lane replication,
// load lane selection with sign/zero extension, and alignment checking.
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  ldst_e              ldst,
  input  logic [1:0]         byte_off,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [DATA_W-1:0]  rdata,
  output logic [MASK_W-1:0]  wmask,
  output logic [DATA_W-1:0]  lane_wdata,
  output logic [DATA_W-1:0]  load_data,
  output logic               misaligned,
  output logic               is_wr
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte 0 lives in the most significant lane.
  always_comb begin
    byte_sel = rdata[31:24];
    case (byte_off)
      2'd0: byte_sel = rdata[31:24];
      2'd1: byte_sel = rdata[23:16];
      2'd2: byte_sel = rdata[15:8];
      2'd3: byte_sel = rdata[7:0];
      default: byte_sel = rdata[31:24];
    endcase
  end

  assign half_sel = byte_off[1] ? rdata[15:0] : rdata[31:16];
  assign is_wr    = is_store(ldst);

  always_comb begin
    // NOTE: every output is defaulted before the case so no branch can infer a latch.
    wmask      = '0;
    lane_wdata = '0;
    load_data  = '0;
    misaligned = 1'b0;
    case (ldst)
      LDST_LB:  load_data = extend_lane({8'h00, byte_sel}, 1'b0, 1'b1);
      LDST_LBU: load_data = extend_lane({8'h00, byte_sel}, 1'b0, 1'b0);
      LDST_LH: begin
        misaligned = byte_off[0];
        load_data  = extend_lane(half_sel, 1'b1, 1'b1);
      end
      LDST_LHU: begin
        misaligned = byte_off[0];
        load_data  = extend_lane(half_sel, 1'b1, 1'b0);
      end
      LDST_LW: begin
        misaligned = |byte_off;
        load_data  = rdata;
      end
      LDST_SB: begin
        wmask      = 4'b1000 >> byte_off;
        lane_wdata = {4{wdata[7:0]}};
      end
      LDST_SH: begin
        misaligned = byte_off[0];
        wmask      = byte_off[1] ? 4'b0011 : 4'b1100;
        lane_wdata = {2{wdata[15:0]}};
      end
      LDST_SW: begin
        misaligned = |byte_off;
        wmask      = 4'b1111;
        lane_wdata = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access,
// alternating grants under contention and stalling the pipeline while waiting.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [2:0]        dm_ldst,
  input  logic [31:0]       dm_wdata,
  output logic              dm_ready,
  output logic [31:0]       dm_rdata,
  output logic              dm_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              stall
);

  state_e state_q, state_d;
  grant_e last_grant_q, cur_grant_q, grant_sel;
  logic   grant_valid;
  logic   err_q;
  logic   busy, done;

  logic [MASK_W-1:0] al_wmask;
  logic [DATA_W-1:0] al_wdata, al_load_data;
  logic              al_misaligned, al_is_wr;

  // Fetches are always word reads; the low fetch address bits carry no information.
  logic if_addr_unused;
  assign if_addr_unused = ^if_addr[1:0];

  // The data requester holds its inputs until dm_ready, so the live lane logic
  // serves both the grant-time store path and the ack-time load path.
  mem_lane_align u_align (
    .ldst       (ldst_e'(dm_ldst)),
    .byte_off   (dm_addr[1:0]),
    .wdata      (dm_wdata),
    .rdata      (mem_rdata),
    .wmask      (al_wmask),
    .lane_wdata (al_wdata),
    .load_data  (al_load_data),
    .misaligned (al_misaligned),
    .is_wr      (al_is_wr)
  );

  always_comb begin
    state_d     = state_q;
    grant_valid = 1'b0;
    grant_sel   = GRANT_IF;
    case (state_q)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          grant_valid = 1'b1;
          if (if_req && dm_req)
            grant_sel = (last_grant_q == GRANT_IF) ? GRANT_DM : GRANT_IF;
          else
            grant_sel = dm_req ? GRANT_DM : GRANT_IF;
          if (grant_sel == GRANT_DM)
            state_d = al_misaligned ? ST_DONE : ST_DM_BUSY;
          else
            state_d = ST_IF_BUSY;
        end
      end
      ST_IF_BUSY, ST_DM_BUSY: begin
        if (mem_ack) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q == ST_IF_BUSY) || (state_q == ST_DM_BUSY);
  assign done     = (state_q == ST_DONE);
  assign mem_req  = busy;
  assign if_ready = done && (cur_grant_q == GRANT_IF);
  assign dm_ready = done && (cur_grant_q == GRANT_DM);
  assign dm_err   = dm_ready && err_q;
  assign stall    = ~rst & ((if_req & ~if_ready) | (dm_req & ~dm_ready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_IF;
      cur_grant_q  <= GRANT_IF;
      err_q        <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wmask    <= '0;
      mem_wdata    <= '0;
      if_rdata     <= '0;
      dm_rdata     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;

      if (grant_valid) begin
        cur_grant_q <= grant_sel;
        if (grant_sel == GRANT_IF) begin
          err_q     <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
          mem_wmask <= '0;
          mem_wdata <= '0;
        end else begin
          err_q     <= al_misaligned;
          mem_we    <= al_is_wr;
          mem_addr  <= {dm_addr[ADDR_W-1:2], 2'b00};
          mem_wmask <= al_wmask;
          mem_wdata <= al_wdata;
          if (al_misaligned) dm_rdata <= '0;
        end
      end

      if (busy && mem_ack) begin
        if (state_q == ST_IF_BUSY) if_rdata <= mem_rdata;
        else                       dm_rdata <= al_load_data;
      end

      if (done) last_grant_q <= cur_grant_q;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a behavioural memory
// responder and an arithmetic lane/arbitration reference model.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        err;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } mem_txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ready, dm_req, dm_ready, dm_err;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [2:0]  dm_ldst;
  logic        mem_req, mem_we, mem_ack, stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ack_delay = 0;
  logic [31:0] next_rdata = '0;
  bit          rand_rdata = 0;
  bit          stray_ack = 0;
  int          mem_req_cycles = 0;
  int          last_ack_cyc = 0;
  mem_txn_t    log_q[$];
  mem_txn_t    last_txn;
  bit          model_last_dm = 0;

  mem_port_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_ldst(dm_ldst), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: size/offset arithmetic over a big-endian word.
  function automatic exp_t model_dm(input logic [2:0] op, input logic [31:0] addr,
                                    input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    int size, off, shift;
    bit sgn;
    longint unsigned szmask, v;
    e = '0; size = 4; sgn = 0;
    off = int'(addr[1:0]);
    case (op)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd3: size = 1;
      3'd4: size = 2;
      3'd5: size = 1;
      3'd6: size = 2;
      default: size = 4;
    endcase
    e.we  = (op >= 3'd5);
    e.err = (off % size) != 0;
    if (e.err) return e;
    shift  = (4 - size - off) * 8;
    szmask = (64'd1 << (8 * size)) - 1;
    if (e.we) begin
      v = longint'(wd) & szmask;
      for (int i = 0; i < 4 / size; i++) e.wdata |= 32'(v << (i * 8 * size));
      e.mask = 4'(((1 << size) - 1) << (4 - size - off));
    end else begin
      v = (longint'(rd) >> shift) & szmask;
      if (sgn && v[8*size-1]) v |= ~szmask;
      e.rdata = 32'(v);
    end
    return e;
  endfunction

  // Memory responder: acks ack_delay cycles after mem_req first appears.
  initial begin
    int       wait_cnt;
    mem_txn_t start;
    wait_cnt = 0;
    start = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_ack = 1'b0;
        wait_cnt = 0;
      end else if (mem_req) begin
        mem_req_cycles++;
        if (wait_cnt == 0) start = '{mem_addr, mem_we, mem_wmask, mem_wdata, 32'h0};
        if (wait_cnt >= ack_delay) begin
          check("mem_addr_stable", mem_addr, start.addr);
          check("mem_wdata_stable", mem_wdata, start.wdata);
          mem_rdata = rand_rdata ? $urandom : next_rdata;
          log_q.push_back('{mem_addr, mem_we, mem_wmask, mem_wdata, mem_rdata});
          mem_ack = 1'b1;
          last_ack_cyc = cyc;
          wait_cnt = 0;
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
          wait_cnt++;
        end
      end else begin
        mem_ack = stray_ack;
        mem_rdata = $urandom;
        wait_cnt = 0;
      end
    end
  end

  task automatic finish_dm(input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input string tag);
    exp_t e;
    mem_txn_t t;
    e = model_dm(op, addr, wd, 32'h0);
    if (e.err) begin
      check({tag, "_err"}, dm_err, 1);
      check({tag, "_err_rdata"}, dm_rdata, 0);
      check({tag, "_err_no_mem"}, log_q.size(), 0);
    end else begin
      check({tag, "_err"}, dm_err, 0);
      check({tag, "_memcnt"}, log_q.size(), 1);
      if (log_q.size() > 0) begin
        t = log_q.pop_front();
        last_txn = t;
        e = model_dm(op, addr, wd, t.rdata);
        check({tag, "_maddr"}, t.addr, {addr[31:2], 2'b00});
        check({tag, "_we"}, t.we, e.we);
        check({tag, "_wmask"}, t.mask, e.mask);
        if (e.we) check({tag, "_mwdata"}, t.wdata, e.wdata);
        else      check({tag, "_rdata"}, dm_rdata, e.rdata);
      end
    end
  endtask

  task automatic finish_if(input logic [31:0] addr, input string tag);
    mem_txn_t t;
    check({tag, "_memcnt"}, log_q.size(), 1);
    if (log_q.size() > 0) begin
      t = log_q.pop_front();
      last_txn = t;
      check({tag, "_maddr"}, t.addr, {addr[31:2], 2'b00});
      check({tag, "_we"}, t.we, 0);
      check({tag, "_wmask"}, t.mask, 0);
      check({tag, "_rdata"}, if_rdata, t.rdata);
    end
  endtask

  task automatic do_if(input logic [31:0] addr, input logic [31:0] rd,
                       input int delay, input string tag);
    int issue;
    bit got;
    @(negedge clk); #1;
    ack_delay = delay; next_rdata = rd; rand_rdata = 0;
    if_addr = addr; if_req = 1'b1; issue = cyc; got = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk); #1;
      if (if_ready) begin got = 1; break; end
      if (n < 4) check({tag, "_stall"}, stall, 1);
    end
    check({tag, "_ready"}, got, 1);
    if (got) begin
      check({tag, "_latency"}, cyc - issue, delay + 2);
      check({tag, "_ack2ready"}, cyc - last_ack_cyc, 1);
      check({tag, "_stall_done"}, stall, 0);
      finish_if(addr, tag);
      model_last_dm = 0;
    end
    if_req = 1'b0;
  endtask

  task automatic do_dm(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int delay, input string tag);
    int issue, req_before;
    bit got;
    exp_t e;
    @(negedge clk); #1;
    e = model_dm(op, addr, wd, rd);
    ack_delay = delay; next_rdata = rd; rand_rdata = 0;
    req_before = mem_req_cycles;
    dm_ldst = op; dm_addr = addr; dm_wdata = wd; dm_req = 1'b1;
    issue = cyc; got = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk); #1;
      if (dm_ready) begin got = 1; break; end
      if (n < 4) check({tag, "_stall"}, stall, 1);
    end
    check({tag, "_ready"}, got, 1);
    if (got) begin
      check({tag, "_latency"}, cyc - issue, e.err ? 1 : delay + 2);
      if (e.err) check({tag, "_no_mem_req"}, mem_req_cycles - req_before, 0);
      finish_dm(op, addr, wd, tag);
      model_last_dm = 1;
    end
    dm_req = 1'b0;
  endtask

  // Both requesters held; each completion reissues until n_acc accesses are done.
  task automatic burst(input int n_acc, input string tag, output logic [7:0] order);
    int issued, done_n;
    bit if_pend, dm_pend, exp_dm, got_dm, got;
    logic [31:0] ia, da, dw;
    logic [2:0] op;
    @(negedge clk); #1;
    rand_rdata = 1; order = '0;
    ia = $urandom; op = 3'($urandom_range(0, 7)); da = $urandom; dw = $urandom;
    if_addr = ia; if_req = 1'b1;
    dm_ldst = op; dm_addr = da; dm_wdata = dw; dm_req = 1'b1;
    issued = 2; done_n = 0; if_pend = 1; dm_pend = 1;
    while (done_n < n_acc) begin
      exp_dm = (if_pend && dm_pend) ? !model_last_dm : dm_pend;
      got = 0;
      for (int n = 0; n < 64; n++) begin
        @(negedge clk); #1;
        if (if_ready || dm_ready) begin got = 1; break; end
      end
      check({tag, "_ready"}, got, 1);
      if (!got) break;
      check({tag, "_both_ready"}, if_ready && dm_ready, 0);
      got_dm = dm_ready;
      check({tag, "_side"}, got_dm, exp_dm);
      order = {order[6:0], got_dm};
      if (got_dm) finish_dm(op, da, dw, tag);
      else        finish_if(ia, tag);
      model_last_dm = got_dm;
      done_n++;
      if (issued < n_acc) begin
        issued++;
        if (got_dm) begin
          op = 3'($urandom_range(0, 7)); da = $urandom; dw = $urandom;
          dm_ldst = op; dm_addr = da; dm_wdata = dw;
        end else begin
          ia = $urandom; if_addr = ia;
        end
      end else begin
        if (got_dm) begin dm_req = 1'b0; dm_pend = 0; end
        else        begin if_req = 1'b0; if_pend = 0; end
      end
    end
    if_req = 1'b0; dm_req = 1'b0; rand_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_last_dm = 0;
    log_q.delete();
  endtask

  initial begin
    logic [7:0] ord;
    rst = 1'b1;
    if_req = 0; if_addr = '0; dm_req = 0; dm_addr = '0; dm_ldst = '0; dm_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_if_ready", if_ready, 0);
    check("rst_dm_ready", dm_ready, 0);
    check("rst_dm_err", dm_err, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wmask", mem_wmask, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_stall", stall, 0);
    rst = 1'b0;

    do_if(32'h100, 32'h8C22_0004, 3, "if_basic");
    check("if_basic_value", if_rdata, 32'h8C22_0004);

    do_dm(3'b000, 32'h203, 32'h0, 32'h1122_33F0, 0, "lb");
    check("lb_value", dm_rdata, 32'hFFFF_FFF0);
    check("lb_word_addr", last_txn.addr, 32'h200);
    do_dm(3'b011, 32'h203, 32'h0, 32'h1122_33F0, 1, "lbu");
    check("lbu_value", dm_rdata, 32'h0000_00F0);
    do_dm(3'b100, 32'h202, 32'h0, 32'h1122_33F0, 0, "lhu");
    check("lhu_value", dm_rdata, 32'h0000_33F0);

    do_dm(3'b101, 32'h301, 32'hAB, 32'h0, 0, "sb");
    check("sb_wmask", last_txn.mask, 4'b0100);
    check("sb_wdata", last_txn.wdata, 32'hABAB_ABAB);
    check("sb_we", last_txn.we, 1);
    do_dm(3'b110, 32'h302, 32'h1234, 32'h0, 2, "sh");
    check("sh_wmask", last_txn.mask, 4'b0011);
    check("sh_wdata", last_txn.wdata, 32'h1234_1234);

    do_reset();
    ack_delay = 0;
    burst(4, "arb", ord);
    check("arb_order", ord, 8'b0000_1010);

    do_dm(3'b010, 32'h402, 32'h0, 32'hDEAD_BEEF, 0, "lw_mis");
    check("lw_mis_rdata", dm_rdata, 0);

    // Reset while a data access waits on the memory.
    @(negedge clk); #1;
    ack_delay = 20;
    dm_ldst = 3'b010; dm_addr = 32'h500; dm_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("midrst_mem_req_before", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_mem_req", mem_req, 0);
    check("midrst_dm_ready", dm_ready, 0);
    check("midrst_stall", stall, 0);
    check("midrst_mem_we", mem_we, 0);
    dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_last_dm = 0;
    stray_ack = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("stray_dm_ready", dm_ready, 0);
      check("stray_if_ready", if_ready, 0);
      check("stray_mem_req", mem_req, 0);
    end
    stray_ack = 0;
    check("stray_no_log", log_q.size(), 0);
    do_if(32'h600, 32'h1357_9BDF, 1, "post_rst_if");

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0: do_if($urandom, $urandom, $urandom_range(0, 3), "rnd_if");
        1: do_dm(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                 $urandom_range(0, 3), "rnd_dm");
        default: begin
          ack_delay = $urandom_range(0, 2);
          burst($urandom_range(2, 6), "rnd_burst", ord);
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
